fifo_wr_ptr: RTL and testbench
==============================

FIFO_WR_PTR -- requirements
Module: fifo_wr_ptr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, meaning address bits; FIFO depth D = 2^WIDTH; pointers are WIDTH+1 bits.
REQ-002 The block SHALL have parameter AF_THR, default 4, meaning the almost-full threshold in free slots.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single write-domain clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 The block SHALL have port W_INC, input, 1 bit: write request for the current cycle.
REQ-006 The block SHALL have port SYNC_RPTR, input, WIDTH+1 bits: Gray read pointer, already two-flop synchronized into CLK.
REQ-007 The block SHALL have port CLR_OVF, input, 1 bit: clears the sticky OVERFLOW flag.
REQ-008 The block SHALL have port W_EN, output, 1 bit: memory write strobe.
REQ-009 The block SHALL have port W_ADDR, output, WIDTH bits: binary memory write address.
REQ-010 The block SHALL have port W_GPTR, output, WIDTH+1 bits: registered Gray write pointer, for synchronization into the read domain.
REQ-011 The block SHALL have port FULL, output, 1 bit: registered full flag.
REQ-012 The block SHALL have port ALMOST_FULL, output, 1 bit: registered almost-full flag.
REQ-013 The block SHALL have port FREE_CNT, output, WIDTH+1 bits: registered free-slot count, range 0..D.
REQ-014 The block SHALL have port OVERFLOW, output, 1 bit: sticky flag for a write attempted while full.

Function
REQ-015 Internal binary pointer WBIN (WIDTH+1 bits) SHALL advance by 1 on each edge where W_INC=1 and FULL=0; otherwise it SHALL hold.
REQ-016 WBIN SHALL wrap modulo 2^(WIDTH+1), from all-ones to 0, with no special handling.
REQ-017 W_EN SHALL equal W_INC AND NOT FULL, combinationally from registered FULL.
REQ-018 W_ADDR SHALL equal WBIN[WIDTH-1:0]; latency from the accepted W_INC edge is 1 cycle.
REQ-019 W_GPTR SHALL be registered as (WBIN_next >> 1) XOR WBIN_next, updating on the same edge as WBIN.
REQ-020 W_GPTR SHALL change by at most one bit per edge and SHALL be driven directly from a flop, with no glitch-capable logic.
REQ-021 FULL SHALL be registered as (Gray WBIN_next == {~SYNC_RPTR[WIDTH:WIDTH-1], SYNC_RPTR[WIDTH-2:0]}); the block requires WIDTH >= 2.
REQ-022 RBIN SHALL be the Gray-to-binary conversion of SYNC_RPTR: RBIN[i] = XOR of SYNC_RPTR[WIDTH:i].
REQ-023 FREE_CNT SHALL be registered as D - ((WBIN_next - RBIN) mod 2^(WIDTH+1)).
REQ-024 ALMOST_FULL SHALL be registered as (free_next <= AF_THR), and SHALL remain 1 while FULL=1.
REQ-025 A read-side advance seen on SYNC_RPTR SHALL be reflected in FULL, ALMOST_FULL and FREE_CNT one edge later.
REQ-026 On an edge with W_INC=1 and FULL=1, WBIN SHALL NOT change and OVERFLOW SHALL set to 1.
REQ-027 OVERFLOW SHALL clear on an edge with CLR_OVF=1; when a set condition and CLR_OVF=1 occur on the same edge, the set SHALL win.
REQ-028 When a write and a read-pointer advance occur on the same edge, the flags SHALL be computed from WBIN_next and the new SYNC_RPTR, giving an unchanged FREE_CNT.

Reset
REQ-029 While RST=1, regardless of CLK: WBIN=0, W_GPTR=0, W_ADDR=0, FULL=0, ALMOST_FULL=0 (given AF_THR < D), FREE_CNT=D, OVERFLOW=0.
REQ-030 W_EN SHALL be 0 whenever FULL=0 and W_INC=0.
REQ-031 Reset asserted mid-operation SHALL abort the state immediately with no pending write completing; the first write after RST deasserts SHALL target W_ADDR=0.

Verification (WIDTH=5, D=32, AF_THR=4)
REQ-032 The bench SHALL cover reset: pulse RST with SYNC_RPTR=0 -> W_GPTR=6'b000000, FREE_CNT=32, FULL=0, ALMOST_FULL=0, OVERFLOW=0.
REQ-033 The bench SHALL cover fill: 32 consecutive W_INC with SYNC_RPTR=0 -> ALMOST_FULL=1 after the 28th edge (FREE_CNT=4); after the 32nd edge FULL=1, FREE_CNT=0, W_GPTR=6'b110000, W_ADDR=0.
REQ-034 The bench SHALL cover write while full: W_INC=1 -> W_EN=0, W_GPTR unchanged, OVERFLOW=1 next edge; then CLR_OVF=1 with W_INC=1 -> OVERFLOW stays 1; CLR_OVF=1 with W_INC=0 -> OVERFLOW=0.
REQ-035 The bench SHALL cover drain: while full, set SYNC_RPTR=6'b000001 (binary 1) -> next edge FULL=0, FREE_CNT=1, ALMOST_FULL=1.
REQ-036 The bench SHALL cover wrap: with SYNC_RPTR tracking 4 slots behind, write past WBIN=63 -> W_GPTR goes 6'b100000 to 6'b000000, W_ADDR goes 31 to 0, FULL stays 0, FREE_CNT=28.
REQ-037 The bench SHALL cover async reset mid-fill: assert RST between edges at WBIN=10 -> outputs take reset values before the next CLK edge; the first write after release uses W_ADDR=0.

Source files
------------

// File: rtl/fifo_wr_ptr.sv
// Write-side pointer and flag logic for an asynchronous FIFO.
// Holds the binary/Gray write pointer and derives FULL, ALMOST_FULL, FREE_CNT and OVERFLOW.
module fifo_wr_ptr #(
    parameter int WIDTH  = 5,
    parameter int AF_THR = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             W_INC,
    input  logic [WIDTH:0]   SYNC_RPTR,
    input  logic             CLR_OVF,
    output logic             W_EN,
    output logic [WIDTH-1:0] W_ADDR,
    output logic [WIDTH:0]   W_GPTR,
    output logic             FULL,
    output logic             ALMOST_FULL,
    output logic [WIDTH:0]   FREE_CNT,
    output logic             OVERFLOW
);

    localparam int             D      = 1 << WIDTH;
    localparam logic [WIDTH:0] DEPTH  = (WIDTH + 1)'(D);
    localparam logic [WIDTH:0] AF_LIM = (WIDTH + 1)'(AF_THR);

    logic [WIDTH:0] wbin;
    logic [WIDTH:0] wbin_next;
    logic [WIDTH:0] wgray_next;
    logic [WIDTH:0] rbin;
    logic [WIDTH:0] used_next;
    logic [WIDTH:0] free_next;
    logic           accept;
    logic           full_next;
    logic           af_next;

    assign accept     = W_INC & ~FULL;
    assign W_EN       = accept;
    assign W_ADDR     = wbin[WIDTH-1:0];
    assign wbin_next  = wbin + {{WIDTH{1'b0}}, accept};
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            rbin[i] = ^(SYNC_RPTR >> i);
        end
    end

    assign used_next = wbin_next - rbin;
    assign free_next = DEPTH - used_next;
    assign full_next = (wgray_next == {~SYNC_RPTR[WIDTH:WIDTH-1], SYNC_RPTR[WIDTH-2:0]});
    assign af_next   = full_next | (free_next <= AF_LIM);

    // Flags are looked ahead from the next pointer so they are exact on the edge they appear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wbin        <= '0;
            W_GPTR      <= '0;
            FULL        <= 1'b0;
            ALMOST_FULL <= 1'b0;
            FREE_CNT    <= DEPTH;
            OVERFLOW    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            W_GPTR      <= wgray_next;
            FULL        <= full_next;
            ALMOST_FULL <= af_next;
            FREE_CNT    <= free_next;
            if (W_INC && FULL) begin
                OVERFLOW <= 1'b1;
            end else if (CLR_OVF) begin
                OVERFLOW <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_ptr.sv
// Directed scoreboard bench for fifo_wr_ptr (WIDTH=5, depth 32, AF_THR=4).
// A count-based model predicts each edge; spot checks pin the key values to constants.
module tb_fifo_wr_ptr;

    logic       CLK;
    logic       RST;
    logic       W_INC;
    logic [5:0] SYNC_RPTR;
    logic       CLR_OVF;
    logic       W_EN;
    logic [4:0] W_ADDR;
    logic [5:0] W_GPTR;
    logic       FULL;
    logic       ALMOST_FULL;
    logic [5:0] FREE_CNT;
    logic       OVERFLOW;

    typedef struct packed {
        logic [5:0] gptr;
        logic [4:0] addr;
        logic       full;
        logic       af;
        logic [5:0] free;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   mw    = 0;
    int   mr    = 0;
    bit   mfull = 0;
    bit   movf  = 0;

    fifo_wr_ptr #(.WIDTH(5), .AF_THR(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .W_INC(W_INC),
        .SYNC_RPTR(SYNC_RPTR),
        .CLR_OVF(CLR_OVF),
        .W_EN(W_EN),
        .W_ADDR(W_ADDR),
        .W_GPTR(W_GPTR),
        .FULL(FULL),
        .ALMOST_FULL(ALMOST_FULL),
        .FREE_CNT(FREE_CNT),
        .OVERFLOW(OVERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [5:0] toGray(input int b);
        logic [5:0] v;
        v = b[5:0];
        return v ^ (v >> 1);
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue what the next rising edge must produce.
    task automatic applyStimulus(input bit winc, input int rb, input bit clr);
        exp_t e;
        int   used;
        bit   acc;
        @(negedge CLK);
        W_INC     = winc;
        SYNC_RPTR = toGray(rb);
        CLR_OVF   = clr;
        #1;
        checkVal("w_en", {31'd0, W_EN}, {31'd0, winc && !mfull});
        acc  = winc && !mfull;
        if (winc && mfull) movf = 1'b1;
        else if (clr) movf = 1'b0;
        mw    = (mw + (acc ? 1 : 0)) % 64;
        mr    = rb & 63;
        used  = (mw - mr) & 63;
        mfull = (used == 32);
        e.gptr = toGray(mw);
        e.addr = 5'(mw % 32);
        e.full = mfull;
        e.free = 6'(32 - used);
        e.af   = ((32 - used) <= 4);
        e.ovf  = movf;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard: observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            checkVal("w_gptr",   {26'd0, W_GPTR},      {26'd0, e.gptr});
            checkVal("w_addr",   {27'd0, W_ADDR},      {27'd0, e.addr});
            checkVal("full",     {31'd0, FULL},        {31'd0, e.full});
            checkVal("almost",   {31'd0, ALMOST_FULL}, {31'd0, e.af});
            checkVal("free_cnt", {26'd0, FREE_CNT},    {26'd0, e.free});
            checkVal("overflow", {31'd0, OVERFLOW},    {31'd0, e.ovf});
        end
    endtask

    task automatic step(input bit winc, input int rb, input bit clr);
        applyStimulus(winc, rb, clr);
        checkOutput();
    endtask

    task automatic checkResetValues(input string phase);
        checkVal({phase, "_gptr"}, {26'd0, W_GPTR},      32'd0);
        checkVal({phase, "_addr"}, {27'd0, W_ADDR},      32'd0);
        checkVal({phase, "_full"}, {31'd0, FULL},        32'd0);
        checkVal({phase, "_af"},   {31'd0, ALMOST_FULL}, 32'd0);
        checkVal({phase, "_free"}, {26'd0, FREE_CNT},    32'd32);
        checkVal({phase, "_ovf"},  {31'd0, OVERFLOW},    32'd0);
        checkVal({phase, "_wen"},  {31'd0, W_EN},        32'd0);
    endtask

    initial begin
        RST       = 1'b1;
        W_INC     = 1'b0;
        SYNC_RPTR = '0;
        CLR_OVF   = 1'b0;
        #12;
        checkResetValues("reset");
        @(negedge CLK);
        RST = 1'b0;

        $display("[TB] fill to full");
        for (int k = 1; k <= 32; k++) begin
            step(1'b1, 0, 1'b0);
            if (k == 27) checkVal("af_edge27", {31'd0, ALMOST_FULL}, 32'd0);
            if (k == 28) begin
                checkVal("af_edge28",   {31'd0, ALMOST_FULL}, 32'd1);
                checkVal("free_edge28", {26'd0, FREE_CNT},    32'd4);
            end
        end
        checkVal("fill_full", {31'd0, FULL},     32'd1);
        checkVal("fill_free", {26'd0, FREE_CNT}, 32'd0);
        checkVal("fill_gptr", {26'd0, W_GPTR},   32'b110000);
        checkVal("fill_addr", {27'd0, W_ADDR},   32'd0);

        $display("[TB] write while full and overflow clear");
        step(1'b1, 0, 1'b0);
        checkVal("ovf_set",     {31'd0, OVERFLOW}, 32'd1);
        checkVal("ovf_gptr",    {26'd0, W_GPTR},   32'b110000);
        step(1'b1, 0, 1'b1);
        checkVal("ovf_setwins", {31'd0, OVERFLOW}, 32'd1);
        step(1'b0, 0, 1'b1);
        checkVal("ovf_clear",   {31'd0, OVERFLOW}, 32'd0);

        $display("[TB] drain one slot");
        step(1'b0, 1, 1'b0);
        checkVal("drain_full", {31'd0, FULL},        32'd0);
        checkVal("drain_free", {26'd0, FREE_CNT},    32'd1);
        checkVal("drain_af",   {31'd0, ALMOST_FULL}, 32'd1);

        $display("[TB] pointer wrap with reader 4 behind");
        step(1'b0, 29, 1'b0);
        while (mw != 63) step(1'b1, (mw + 1 - 4) & 63, 1'b0);
        checkVal("pre_wrap_gptr", {26'd0, W_GPTR}, 32'b100000);
        checkVal("pre_wrap_addr", {27'd0, W_ADDR}, 32'd31);
        step(1'b1, (mw + 1 - 4) & 63, 1'b0);
        checkVal("wrap_gptr", {26'd0, W_GPTR},   32'd0);
        checkVal("wrap_addr", {27'd0, W_ADDR},   32'd0);
        checkVal("wrap_full", {31'd0, FULL},     32'd0);
        checkVal("wrap_free", {26'd0, FREE_CNT}, 32'd28);

        $display("[TB] async reset mid-fill");
        for (int k = 0; k < 10; k++) step(1'b1, (mw + 1 - 4) & 63, 1'b0);
        checkVal("midfill_addr", {27'd0, W_ADDR}, 32'd10);
        #2;
        RST       = 1'b1;
        W_INC     = 1'b0;
        SYNC_RPTR = '0;
        #1;
        checkResetValues("async");
        mw    = 0;
        mr    = 0;
        mfull = 1'b0;
        movf  = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        applyStimulus(1'b1, 0, 1'b0);
        checkVal("post_rst_addr", {27'd0, W_ADDR}, 32'd0);
        checkVal("post_rst_wen",  {31'd0, W_EN},   32'd1);
        checkOutput();
        checkVal("post_rst_next", {27'd0, W_ADDR}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
